// File: rtl/uart_waveform_rx_pkg.sv
// Shared types and constants for the waveform UART receiver.
package uart_wave_pkg;

   typedef enum logic [2:0] {
      HUNT,
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   localparam int         BYTES_PER_REC   = 3;
   localparam logic [7:0] TRAILER_PAD     = 8'h00;
   localparam int         FRAME_DATA_BITS = 8;

   // One assembled record: 14-bit sample plus the index byte that followed it.
   typedef struct packed {
      logic [13:0] data;
      logic [7:0]  idx;
   } wave_rec_t;

   // Index byte the transmitter should send for a record counter value (wraps at 256).
   function automatic logic [7:0] next_idx(input logic [7:0] cnt_lsb);
      return cnt_lsb + 8'd1;
   endfunction

endpackage

// File: rtl/uart_waveform_rx_byte_rx.sv
// Byte-level UART receiver: 2-FF synchroniser, frame FSM and bit timer.
// Emits byte_done / frame_err as single-cycle strobes on the last stop-bit sample.
module uart_byte_rx
   import uart_wave_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1,
   parameter int STOP_BITS    = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rx,
   input  logic       hunt_done,
   input  logic       hunt_req,
   output rx_state_t  state,
   output logic       rx_line,
   output logic       byte_done,
   output logic [7:0] rx_byte,
   output logic       frame_err
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW   = $clog2(FRAME_DATA_BITS + STOP_BITS);

   localparam logic [TW-1:0] T_HALF    = TW'(HALF);
   localparam logic [TW-1:0] T_LAST    = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_ONE     = TW'(1);
   localparam logic [BW-1:0] LAST_DATA = BW'(FRAME_DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   logic                       rx_meta_reg;
   logic                       rx_sync_reg;
   rx_state_t                  state_reg, state_next;
   logic [TW-1:0]              timer_reg, timer_next;
   logic [BW-1:0]              bit_cnt_reg, bit_cnt_next;
   logic [FRAME_DATA_BITS-1:0] shift_reg, shift_next;
   logic                       stop_bad_reg, stop_bad_next;
   logic                       bit_tick;
   logic                       last_stop;
   logic                       stop_ok;

   // Two-flop synchroniser; the line idles high so reset parks it high.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
      end else begin
         rx_meta_reg <= uart_rx;
         rx_sync_reg <= rx_meta_reg;
      end
   end

   // State register and datapath registers; reset discards any partial byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= HUNT;
         timer_reg    <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         stop_bad_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         stop_bad_reg <= stop_bad_next;
      end
   end

   assign bit_tick  = (timer_reg == T_LAST);
   assign last_stop = (state_reg == STOP) && bit_tick && (bit_cnt_reg == LAST_STOP);
   assign stop_ok   = !stop_bad_reg && rx_sync_reg;

   // Next-state logic. With HALF==0 the start bit is confirmed in the detect cycle,
   // which keeps back-to-back frames at one clock per bit aligned.
   always_comb begin
      state_next    = state_reg;
      timer_next    = timer_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      stop_bad_next = stop_bad_reg;
      case (state_reg)
         HUNT: begin
            if (hunt_done) state_next = IDLE;
         end
         IDLE: begin
            if (!rx_sync_reg) begin
               bit_cnt_next = '0;
               if (HALF == 0) begin
                  state_next = DATA;
                  timer_next = '0;
               end else begin
                  state_next = START;
                  timer_next = T_ONE;
               end
            end
         end
         START: begin
            if (timer_reg == T_HALF) begin
               timer_next = '0;
               state_next = rx_sync_reg ? IDLE : DATA;
            end else begin
               timer_next = timer_reg + T_ONE;
            end
         end
         DATA: begin
            if (bit_tick) begin
               timer_next = '0;
               shift_next = {rx_sync_reg, shift_reg[FRAME_DATA_BITS-1:1]};
               if (bit_cnt_reg == LAST_DATA) begin
                  state_next    = STOP;
                  bit_cnt_next  = '0;
                  stop_bad_next = 1'b0;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end else begin
               timer_next = timer_reg + T_ONE;
            end
         end
         STOP: begin
            if (bit_tick) begin
               timer_next = '0;
               if (bit_cnt_reg == LAST_STOP) begin
                  if (!stop_ok || hunt_req) state_next = HUNT;
                  else                      state_next = IDLE;
               end else begin
                  bit_cnt_next  = bit_cnt_reg + 1'b1;
                  stop_bad_next = stop_bad_reg | !rx_sync_reg;
               end
            end else begin
               timer_next = timer_reg + T_ONE;
            end
         end
         default: state_next = HUNT;
      endcase
   end

   // Output strobes decoded from the current state.
   always_comb begin
      byte_done = last_stop && stop_ok;
      frame_err = last_stop && !stop_ok;
   end

   assign state   = state_reg;
   assign rx_line = rx_sync_reg;
   assign rx_byte = shift_reg;

endmodule

// File: rtl/uart_waveform_rx.sv
// Waveform stream receiver: line-quiet (HUNT) timer plus {hi, lo, idx} record framer
// on top of the byte receiver. Emits samples, then decodes the wave-number trailer.
module uart_waveform_rx
   import uart_wave_pkg::*;
#(
   parameter  int CLKS_PER_BIT = 1,
   parameter  int STOP_BITS    = 3,
   parameter  int NUM_SAMPLES  = 1000,   // must be >= 2
   parameter  int IDLE_BITS    = 24,
   localparam int IDX_W        = $clog2(NUM_SAMPLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             uart_rx,
   output logic             sample_valid,
   output logic [13:0]      sample_data,
   output logic [IDX_W-1:0] sample_index,
   output logic             wave_valid,
   output logic [15:0]      wave_number,
   output logic             frame_err,
   output logic             seq_err,
   output logic             busy
);

   localparam int HUNT_CYCLES = IDLE_BITS * CLKS_PER_BIT;
   localparam int HW          = $clog2(HUNT_CYCLES + 1);
   localparam int CW          = IDX_W + 1;

   localparam logic [HW-1:0] QUIET_CNT = HW'(HUNT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_SAMPLES);
   localparam logic [1:0]    POS_IDX   = 2'(BYTES_PER_REC - 1);

   rx_state_t        state;
   logic             rx_line;
   logic             byte_done;
   logic [7:0]       rx_byte;
   logic             frame_err_raw;
   logic             hunt_req;
   logic             line_quiet;
   logic             framer_clear;
   logic             rec_complete;
   logic             is_trailer;
   logic [7:0]       cnt_lsb;
   wave_rec_t        cur_rec;

   logic [HW-1:0]    high_cnt_reg;
   logic [1:0]       byte_pos_reg;
   logic [7:0]       hi_reg;
   logic [7:0]       lo_reg;
   logic [CW-1:0]    rec_cnt_reg;
   logic             sample_valid_reg;
   logic [13:0]      sample_data_reg;
   logic [IDX_W-1:0] sample_index_reg;
   logic             wave_valid_reg;
   logic [15:0]      wave_number_reg;
   logic             frame_err_reg;
   logic             seq_err_reg;

   uart_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .STOP_BITS    (STOP_BITS)
   ) u_byte_rx (
      .clk       (clk),
      .reset     (reset),
      .uart_rx   (uart_rx),
      .hunt_done (line_quiet),
      .hunt_req  (hunt_req),
      .state     (state),
      .rx_line   (rx_line),
      .byte_done (byte_done),
      .rx_byte   (rx_byte),
      .frame_err (frame_err_raw)
   );

   // Low byte of the record counter, zero-extended when the counter is narrower.
   generate
      if (CW >= 8) begin : g_cnt_wide
         assign cnt_lsb = rec_cnt_reg[7:0];
      end else begin : g_cnt_narrow
         assign cnt_lsb = {{(8 - CW){1'b0}}, rec_cnt_reg};
      end
   endgenerate

   assign cur_rec      = {hi_reg[5:0], lo_reg, rx_byte};
   assign rec_complete = byte_done && (byte_pos_reg == POS_IDX);
   assign is_trailer   = (rec_cnt_reg == CNT_LAST);
   assign hunt_req     = rec_complete && is_trailer;
   assign line_quiet   = (high_cnt_reg == QUIET_CNT);
   assign framer_clear = line_quiet && ((state == HUNT) || (state == IDLE));
   assign busy         = !((state == HUNT) || (state == IDLE));

   // Counts consecutive high line samples while waiting between frames; saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         high_cnt_reg <= '0;
      end else if (((state == HUNT) || (state == IDLE)) && rx_line) begin
         if (!line_quiet) high_cnt_reg <= high_cnt_reg + 1'b1;
      end else begin
         high_cnt_reg <= '0;
      end
   end

   // Record framer: collects hi/lo/idx, emits a sample or the trailer, flags index errors.
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_pos_reg     <= '0;
         hi_reg           <= '0;
         lo_reg           <= '0;
         rec_cnt_reg      <= '0;
         sample_valid_reg <= 1'b0;
         sample_data_reg  <= '0;
         sample_index_reg <= '0;
         wave_valid_reg   <= 1'b0;
         wave_number_reg  <= '0;
         frame_err_reg    <= 1'b0;
         seq_err_reg      <= 1'b0;
      end else begin
         sample_valid_reg <= 1'b0;
         wave_valid_reg   <= 1'b0;
         seq_err_reg      <= 1'b0;
         frame_err_reg    <= frame_err_raw;
         if (frame_err_raw) begin
            byte_pos_reg <= '0;
         end else if (byte_done) begin
            case (byte_pos_reg)
               2'd0: begin
                  hi_reg       <= rx_byte;
                  byte_pos_reg <= 2'd1;
               end
               2'd1: begin
                  lo_reg       <= rx_byte;
                  byte_pos_reg <= 2'd2;
               end
               default: begin
                  byte_pos_reg <= '0;
                  if (!is_trailer) begin
                     sample_valid_reg <= 1'b1;
                     sample_data_reg  <= cur_rec.data;
                     sample_index_reg <= rec_cnt_reg[IDX_W-1:0];
                     seq_err_reg      <= (cur_rec.idx != next_idx(cnt_lsb));
                     rec_cnt_reg      <= rec_cnt_reg + 1'b1;
                  end else begin
                     wave_valid_reg   <= 1'b1;
                     wave_number_reg  <= {hi_reg, lo_reg};
                     seq_err_reg      <= (cur_rec.idx != TRAILER_PAD);
                     rec_cnt_reg      <= '0;
                  end
               end
            endcase
         end else if (framer_clear) begin
            byte_pos_reg <= '0;
            rec_cnt_reg  <= '0;
         end
      end
   end

   assign sample_valid = sample_valid_reg;
   assign sample_data  = sample_data_reg;
   assign sample_index = sample_index_reg;
   assign wave_valid   = wave_valid_reg;
   assign wave_number  = wave_number_reg;
   assign frame_err    = frame_err_reg;
   assign seq_err      = seq_err_reg;

endmodule

// File: tb/tb_uart_waveform_rx.sv
// Scoreboard bench for uart_waveform_rx: three instances (short waveform at 1 clk/bit,
// 16 clk/bit, and a 300-sample waveform for index wrap).
module tb_uart_waveform_rx;

   typedef struct {
      bit          wave;
      logic [15:0] val;
      int          idx;
      bit          seq;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        line [3];
   logic        sv [3];
   logic        wv [3];
   logic        fe [3];
   logic        se [3];
   logic        bz [3];
   logic [13:0] sd [3];
   logic [15:0] wn [3];
   logic [15:0] si [3];
   logic [1:0]  si_a;
   logic [1:0]  si_b;
   logic [8:0]  si_c;

   exp_t        sb [3][$];
   int          fe_cnt [3];
   logic        fe_prev [3];
   int          errors = 0;
   int          checks = 0;
   exp_t        mon_e;
   logic [15:0] mon_val;
   bit          mon_ok;

   always #5 clk = ~clk;

   assign si[0] = {14'b0, si_a};
   assign si[1] = {14'b0, si_b};
   assign si[2] = {7'b0, si_c};

   uart_waveform_rx #(.CLKS_PER_BIT(1), .STOP_BITS(3), .NUM_SAMPLES(4), .IDLE_BITS(24)) u_a (
      .clk(clk), .reset(reset), .uart_rx(line[0]),
      .sample_valid(sv[0]), .sample_data(sd[0]), .sample_index(si_a),
      .wave_valid(wv[0]), .wave_number(wn[0]), .frame_err(fe[0]), .seq_err(se[0]), .busy(bz[0]));

   uart_waveform_rx #(.CLKS_PER_BIT(16), .STOP_BITS(3), .NUM_SAMPLES(4), .IDLE_BITS(24)) u_b (
      .clk(clk), .reset(reset), .uart_rx(line[1]),
      .sample_valid(sv[1]), .sample_data(sd[1]), .sample_index(si_b),
      .wave_valid(wv[1]), .wave_number(wn[1]), .frame_err(fe[1]), .seq_err(se[1]), .busy(bz[1]));

   uart_waveform_rx #(.CLKS_PER_BIT(1), .STOP_BITS(3), .NUM_SAMPLES(300), .IDLE_BITS(24)) u_c (
      .clk(clk), .reset(reset), .uart_rx(line[2]),
      .sample_valid(sv[2]), .sample_data(sd[2]), .sample_index(si_c),
      .wave_valid(wv[2]), .wave_number(wn[2]), .frame_err(fe[2]), .seq_err(se[2]), .busy(bz[2]));

   function automatic int cpb(input int k);
      return (k == 1) ? 16 : 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic hold(input int k, input logic v, input int bits);
      for (int i = 0; i < bits * cpb(k); i++) begin
         @(negedge clk);
         line[k] = v;
      end
   endtask

   // stops[j] is the level driven on stop bit j (1 = correct).
   task automatic send_byte(input int k, input logic [7:0] b, input logic [2:0] stops);
      hold(k, 1'b0, 1);
      for (int i = 0; i < 8; i++) hold(k, b[i], 1);
      for (int j = 0; j < 3; j++) hold(k, stops[j], 1);
   endtask

   task automatic send_rec(input int k, input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] ix);
      send_byte(k, hi, 3'b111);
      send_byte(k, lo, 3'b111);
      send_byte(k, ix, 3'b111);
   endtask

   task automatic push(input int k, input bit w, input logic [15:0] v, input int ix, input bit sq);
      exp_t e;
      e.wave = w;
      e.val  = v;
      e.idx  = ix;
      e.seq  = sq;
      sb[k].push_back(e);
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_sample_valid"}, {31'b0, sv[0]}, 32'd0);
      chk({tag, "_wave_valid"},   {31'b0, wv[0]}, 32'd0);
      chk({tag, "_frame_err"},    {31'b0, fe[0]}, 32'd0);
      chk({tag, "_seq_err"},      {31'b0, se[0]}, 32'd0);
      chk({tag, "_busy"},         {31'b0, bz[0]}, 32'd0);
      chk({tag, "_sample_data"},  {18'b0, sd[0]}, 32'd0);
      chk({tag, "_sample_index"}, {16'b0, si[0]}, 32'd0);
      chk({tag, "_wave_number"},  {16'b0, wn[0]}, 32'd0);
   endtask

   // Monitor: pops the scoreboard on every strobe, checks strobe widths and seq_err alignment.
   always @(negedge clk) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) fe_prev[k] = 1'b0;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (sv[k] || wv[k]) begin
               checks++;
               mon_val = wv[k] ? wn[k] : {2'b00, sd[k]};
               if (sb[k].size() == 0) begin
                  errors++;
                  $display("FAIL strobe_unexpected inst%0d: got sv=%0b wv=%0b val=%h, required no strobe",
                           k, sv[k], wv[k], mon_val);
               end else begin
                  mon_e  = sb[k].pop_front();
                  mon_ok = (wv[k] == mon_e.wave) && (sv[k] == !mon_e.wave) && (mon_val == mon_e.val) &&
                           (mon_e.wave || (si[k] == 16'(mon_e.idx))) && (se[k] == mon_e.seq);
                  if (!mon_ok) begin
                     errors++;
                     $display("FAIL record inst%0d: got wave=%0b val=%h idx=%0d seq=%0b, required wave=%0b val=%h idx=%0d seq=%0b",
                              k, wv[k], mon_val, si[k], se[k], mon_e.wave, mon_e.val, mon_e.idx, mon_e.seq);
                  end else begin
                     $display("inst%0d %s val=%h idx=%0d seq=%0b", k, wv[k] ? "wave  " : "sample",
                              mon_val, si[k], se[k]);
                  end
               end
            end
            if (se[k]) begin
               checks++;
               if (!(sv[k] || wv[k])) begin
                  errors++;
                  $display("FAIL seq_err_alone inst%0d: got seq_err=1 without strobe, required 0", k);
               end
            end
            if (fe[k]) begin
               fe_cnt[k]++;
               checks++;
               if (fe_prev[k]) begin
                  errors++;
                  $display("FAIL frame_err_width inst%0d: got 2+ cycle pulse, required 1 cycle", k);
               end
            end
            fe_prev[k] = fe[k];
         end
      end
   end

   initial begin
      logic [7:0] hi;
      logic [7:0] lo;
      logic [7:0] ix;
      bit         seen_busy;

      for (int k = 0; k < 3; k++) begin
         line[k]   = 1'b1;
         fe_cnt[k] = 0;
      end
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_reset_a("init");

      // 1: full waveform, then trailer; a record right after the trailer must be ignored (HUNT)
      hold(0, 1'b1, 30);
      push(0, 0, 16'h1ABC, 0, 0); send_rec(0, 8'h1A, 8'hBC, 8'h01);
      push(0, 0, 16'h0001, 1, 0); send_rec(0, 8'h00, 8'h01, 8'h02);
      push(0, 0, 16'h3FFF, 2, 0); send_rec(0, 8'h3F, 8'hFF, 8'h03);
      push(0, 0, 16'h0000, 3, 0); send_rec(0, 8'h00, 8'h00, 8'h04);
      push(0, 1, 16'h1234, 0, 0); send_rec(0, 8'h12, 8'h34, 8'h00);
      send_rec(0, 8'h01, 8'h01, 8'h01);
      hold(0, 1'b1, 4);
      chk("t1_busy_after", {31'b0, bz[0]}, 32'd0);

      // 2: second stop bit of record 1 lo byte low -> frame_err, rest ignored until line quiet
      hold(0, 1'b1, 30);
      push(0, 0, 16'h1122, 0, 0); send_rec(0, 8'h11, 8'h22, 8'h01);
      send_byte(0, 8'h33, 3'b111);
      send_byte(0, 8'h44, 3'b101);
      send_byte(0, 8'h02, 3'b111);
      send_rec(0, 8'h00, 8'h00, 8'h03);
      hold(0, 1'b1, 30);
      push(0, 0, 16'h0555, 0, 0); send_rec(0, 8'h05, 8'h55, 8'h01);

      // 3: wrong index byte still emits the sample with seq_err
      hold(0, 1'b1, 30);
      push(0, 0, 16'h0A0B, 0, 1); send_rec(0, 8'h0A, 8'h0B, 8'h05);
      push(0, 0, 16'h2CDD, 1, 0); send_rec(0, 8'h2C, 8'hDD, 8'h02);

      // 5: reset in the middle of a hi byte's data bits
      hold(0, 1'b1, 30);
      hold(0, 1'b0, 1);
      hold(0, 1'b1, 1);
      hold(0, 1'b0, 1);
      hold(0, 1'b1, 1);
      @(negedge clk);
      line[0] = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk_reset_a("midreset");
      reset = 1'b0;
      send_rec(0, 8'h00, 8'h00, 8'h01);
      hold(0, 1'b1, 30);
      push(0, 0, 16'h0102, 0, 0); send_rec(0, 8'h01, 8'h02, 8'h01);

      // 4: 16 clk/bit, 3-cycle glitch must not confirm a start bit
      hold(1, 1'b1, 30);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         line[1] = 1'b0;
      end
      @(negedge clk);
      line[1] = 1'b1;
      seen_busy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bz[1]) seen_busy = 1;
      end
      chk("t4_glitch_busy_seen", {31'b0, seen_busy}, 32'd1);
      chk("t4_glitch_busy_end", {31'b0, bz[1]}, 32'd0);
      push(1, 0, 16'h2A55, 0, 0); send_rec(1, 8'h2A, 8'h55, 8'h01);

      // 6: 257 records, index byte wraps to 0x00 at record 255, hi[7:6] set
      hold(2, 1'b1, 30);
      for (int r = 0; r < 257; r++) begin
         hi = {2'b11, 6'(r)};
         lo = 8'(r) ^ 8'h5A;
         ix = 8'(r + 1);
         push(2, 0, {2'b00, hi[5:0], lo}, r, 0);
         send_rec(2, hi, lo, ix);
      end

      hold(2, 1'b1, 40);
      for (int k = 0; k < 3; k++) chk($sformatf("drain_inst%0d", k), sb[k].size(), 32'd0);
      chk("frame_err_count_inst0", fe_cnt[0], 32'd1);
      chk("frame_err_count_inst1", fe_cnt[1], 32'd0);
      chk("frame_err_count_inst2", fe_cnt[2], 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
